// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register slice.
//   MODE_* : 2-bit operation encodings presented on the mode input
//   state_t: control state of the burst sequencer (IDLE, SHIFT, DONE)
package univ_shift_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/univ_shift_reg_step.sv
// usr_step: purely combinational single-operation datapath.
// Ports:
//   q        in  WIDTH : current register contents
//   mode     in  2     : hold / shift right / shift left / load
//   rotate   in  1     : recirculate the outgoing bit instead of the serial input
//   s_in_r   in  1     : serial bit entering the MSB on a right shift
//   s_in_l   in  1     : serial bit entering the LSB on a left shift
//   p_in     in  WIDTH : parallel load data
//   q_next   out WIDTH : register contents after the operation
//   out_bit  out 1     : bit that left the register (valid when shifted=1)
//   shifted  out 1     : high when the operation was a shift
module usr_step
   import univ_shift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  logic [1:0]       mode,
   input  logic             rotate,
   input  logic             s_in_r,
   input  logic             s_in_l,
   input  logic [WIDTH-1:0] p_in,
   output logic [WIDTH-1:0] q_next,
   output logic             out_bit,
   output logic             shifted
);

   // Evaluate one operation; hold is the default so every output has a
   // defined value on every path.
   always_comb begin
      q_next  = q;
      out_bit = 1'b0;
      shifted = 1'b0;
      case (mode)
         MODE_SHR: begin
            q_next  = {(rotate ? q[0] : s_in_r), q[WIDTH-1:1]};
            out_bit = q[0];
            shifted = 1'b1;
         end
         MODE_SHL: begin
            q_next  = {q[WIDTH-2:0], (rotate ? q[WIDTH-1] : s_in_l)};
            out_bit = q[WIDTH-1];
            shifted = 1'b1;
         end
         MODE_LOAD: begin
            q_next = p_in;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register with single-step and
// counted-burst operation.
// Ports:
//   clk, rst         : clock and synchronous active-high reset
//   en               : perform one mode operation (IDLE only)
//   mode, rotate     : operation select and rotate enable
//   s_in_r, s_in_l   : serial inputs for right / left shifts
//   p_in             : parallel load data
//   start, count     : burst request and number of shifts
//   q, s_out         : register contents and last shifted-out bit
//   busy, done       : burst in progress / one-cycle completion pulse
module univ_shift_reg
   import univ_shift_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             rotate,
   input  logic             s_in_r,
   input  logic             s_in_l,
   input  logic [WIDTH-1:0] p_in,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] q,
   output logic             s_out,
   output logic             busy,
   output logic             done
);

   state_t           state;
   state_t           state_next;
   logic [1:0]       run_mode;
   logic             run_rotate;
   logic [CNT_W-1:0] remaining;

   logic [1:0]       step_mode;
   logic             step_rotate;
   logic [WIDTH-1:0] step_q;
   logic             step_bit;
   logic             step_shifted;
   logic             start_burst;

   // A start only turns into a real burst for a shift mode with a nonzero
   // count; every other start completes immediately via DONE.
   assign start_burst = start && ((mode == MODE_SHR) || (mode == MODE_SHL))
                        && (count != '0);

   // During a burst the step unit must use the latched mode/rotate, since
   // the live inputs are ignored while shifting.
   assign step_mode   = (state == SHIFT) ? run_mode   : mode;
   assign step_rotate = (state == SHIFT) ? run_rotate : rotate;

   usr_step #(.WIDTH(WIDTH)) u_step (
      .q       (q),
      .mode    (step_mode),
      .rotate  (step_rotate),
      .s_in_r  (s_in_r),
      .s_in_l  (s_in_l),
      .p_in    (p_in),
      .q_next  (step_q),
      .out_bit (step_bit),
      .shifted (step_shifted)
   );

   // State register; reset abandons any burst without passing through DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: start beats en in IDLE, the burst ends after the
   // shift that consumes the last remaining count, DONE lasts one cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = start_burst ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            if (remaining == CNT_W'(1)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: register contents, shifted-out bit and the burst down-counter.
   // A load-mode start reuses the step unit so the load happens on the
   // accepting edge; hold-mode and zero-count starts leave q untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         q          <= '0;
         s_out      <= 1'b0;
         remaining  <= '0;
         run_mode   <= MODE_HOLD;
         run_rotate <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (mode == MODE_LOAD) begin
                     q <= step_q;
                  end
                  if (start_burst) begin
                     run_mode   <= mode;
                     run_rotate <= rotate;
                     remaining  <= count;
                  end
               end else if (en) begin
                  q <= step_q;
                  if (step_shifted) begin
                     s_out <= step_bit;
                  end
               end
            end
            SHIFT: begin
               q         <= step_q;
               s_out     <= step_bit;
               remaining <= remaining - CNT_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

   // Handshake outputs decode straight from the state register.
   assign busy = (state == SHIFT);
   assign done = (state == DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8). A behavioural model
// tracks the expected register, shifted-out bit and handshake every cycle;
// directed scenarios add literal expectations that pin both DUT and model.
module tb_univ_shift_reg;

   localparam int W  = 8;
   localparam int CW = $clog2(W) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic          rotate = 1'b0;
   logic          s_in_r = 1'b0;
   logic          s_in_l = 1'b0;
   logic [W-1:0]  p_in = '0;
   logic          start = 1'b0;
   logic [CW-1:0] count = '0;
   logic [W-1:0]  q;
   logic          s_out;
   logic          busy;
   logic          done;

   int checks = 0;
   int errors = 0;

   univ_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .mode   (mode),
      .rotate (rotate),
      .s_in_r (s_in_r),
      .s_in_l (s_in_l),
      .p_in   (p_in),
      .start  (start),
      .count  (count),
      .q      (q),
      .s_out  (s_out),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   // Behavioural model state: the number of shifts still owed by a burst
   // stands in for busy, and a single flag for the done pulse.
   int       m_q = 0;
   bit       m_s = 1'b0;
   int       m_left = 0;
   bit       m_done = 1'b0;
   int       m_dir = 0;
   bit       m_rot = 1'b0;
   bit       m_valid = 1'b0;

   // One shift as arithmetic: dir 1 = right (divide), dir 2 = left (multiply).
   // Returns {bit out, new value}.
   function automatic logic [W:0] shiftOp(input int val, input int dir,
                                          input bit rot, input bit sr,
                                          input bit sl);
      int outb;
      int fill;
      int nv;
      if (dir == 1) begin
         outb = val % 2;
         fill = rot ? outb : int'(sr);
         nv   = (val / 2) + fill * (1 << (W - 1));
      end else begin
         outb = val / (1 << (W - 1));
         fill = rot ? outb : int'(sl);
         nv   = ((val * 2) % (1 << W)) + fill;
      end
      return {outb[0], nv[W-1:0]};
   endfunction

   // Advance the model on every rising edge from the inputs driven at the
   // preceding falling edge.
   always @(posedge clk) begin
      logic [W:0] r;
      if (rst) begin
         m_q     <= 0;
         m_s     <= 1'b0;
         m_left  <= 0;
         m_done  <= 1'b0;
         m_valid <= 1'b1;
      end else if (m_left > 0) begin
         r = shiftOp(m_q, m_dir, m_rot, s_in_r, s_in_l);
         m_q    <= int'(r[W-1:0]);
         m_s    <= r[W];
         m_left <= m_left - 1;
         m_done <= (m_left == 1);
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (start) begin
         if ((mode == 2'b01 || mode == 2'b10) && count > 0) begin
            m_left <= int'(count);
            m_dir  <= int'(mode);
            m_rot  <= rotate;
         end else begin
            m_done <= 1'b1;
            if (mode == 2'b11) m_q <= int'(p_in);
         end
      end else if (en) begin
         if (mode == 2'b01 || mode == 2'b10) begin
            r = shiftOp(m_q, int'(mode), rotate, s_in_r, s_in_l);
            m_q <= int'(r[W-1:0]);
            m_s <= r[W];
         end else if (mode == 2'b11) begin
            m_q <= int'(p_in);
         end
      end
   end

   // Compare DUT against the model 1 time unit after every rising edge.
   always @(posedge clk) begin
      #1;
      if (m_valid) begin
         checks++;
         if (q !== m_q[W-1:0] || s_out !== m_s || busy !== (m_left > 0) ||
             done !== m_done || (busy && done)) begin
            errors++;
            $display("[TB] FAIL model_cmp t=%0t actual q=%h s_out=%b busy=%b done=%b required q=%h s_out=%b busy=%b done=%b",
                     $time, q, s_out, busy, done, m_q[W-1:0], m_s,
                     (m_left > 0), m_done);
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic e, input logic [1:0] md,
                                input logic rot, input logic sr,
                                input logic sl, input logic [W-1:0] pd,
                                input logic st, input logic [CW-1:0] cnt);
      en     = e;
      mode   = md;
      rotate = rot;
      s_in_r = sr;
      s_in_l = sl;
      p_in   = pd;
      start  = st;
      count  = cnt;
   endtask

   task automatic checkOutput(input string name, input logic [W-1:0] exp_q,
                              input logic exp_s, input logic exp_b,
                              input logic exp_d);
      checks++;
      if (q !== exp_q || s_out !== exp_s || busy !== exp_b || done !== exp_d) begin
         errors++;
         $display("[TB] FAIL %s actual q=%h s_out=%b busy=%b done=%b required q=%h s_out=%b busy=%b done=%b",
                  name, q, s_out, busy, done, exp_q, exp_s, exp_b, exp_d);
      end
      checks++;
      if (m_q[W-1:0] !== exp_q || m_s !== exp_s) begin
         errors++;
         $display("[TB] FAIL %s_model actual q=%h s_out=%b required q=%h s_out=%b",
                  name, m_q[W-1:0], m_s, exp_q, exp_s);
      end
   endtask

   task automatic idle();
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
   endtask

   initial begin
      // Reset
      idle();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      checkOutput("reset", 8'h00, 1'b0, 1'b0, 1'b0);

      // Load then right step
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd0);
      tick();
      checkOutput("load_a5", 8'hA5, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
      tick();
      checkOutput("shr_step", 8'hD2, 1'b1, 1'b0, 1'b0);

      // Left step, plain and rotate
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd0);
      tick();
      applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
      tick();
      checkOutput("shl_step", 8'h4A, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd0);
      tick();
      applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
      tick();
      checkOutput("rol_step", 8'h4B, 1'b1, 1'b0, 1'b0);

      // Hold with en leaves everything alone
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 4'd0);
      tick();
      checkOutput("hold_step", 8'h4B, 1'b1, 1'b0, 1'b0);

      // Rotate-right burst of 3 with noise on ignored inputs
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd0);
      tick();
      applyStimulus(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 4'd3);
      tick();
      checkOutput("ror_accept", 8'hA5, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 4'd7);
      tick();
      checkOutput("ror_shift1", 8'hD2, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 8'h0F, 1'b1, 4'd1);
      tick(2);
      checkOutput("ror_done", 8'hB4, 1'b1, 1'b0, 1'b1);
      idle();
      tick();
      checkOutput("ror_idle", 8'hB4, 1'b1, 1'b0, 1'b0);

      // Fill burst: 8 left shifts of ones into zero
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
      tick();
      applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 4'd8);
      tick();
      start = 1'b0;
      tick(7);
      checkOutput("fill_7", 8'h7F, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("fill_done", 8'hFF, 1'b0, 1'b0, 1'b1);
      idle();
      tick();
      checkOutput("fill_idle", 8'hFF, 1'b0, 1'b0, 1'b0);

      // Degenerate starts
      applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0);
      tick();
      checkOutput("cnt0_done", 8'hFF, 1'b0, 1'b0, 1'b1);
      idle();
      tick();
      applyStimulus(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 4'd5);
      tick();
      checkOutput("load_start", 8'h3C, 1'b0, 1'b0, 1'b1);
      idle();
      tick();
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b1, 4'd4);
      tick();
      checkOutput("hold_start", 8'h3C, 1'b0, 1'b0, 1'b1);
      idle();
      tick();

      // Reset in the middle of a count=5 burst
      applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd5);
      tick();
      start = 1'b0;
      tick();
      checkOutput("mid_shift1", 8'h1E, 1'b0, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 4'd2);
      tick();
      checkOutput("post_rst_accept", 8'h00, 1'b0, 1'b1, 1'b0);
      idle();
      s_in_l = 1'b1;
      tick(2);
      checkOutput("post_rst_done", 8'h03, 1'b0, 1'b0, 1'b1);
      idle();
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register, WIDTH bits wide. Supports hold, right shift, left shift and parallel load, each with an optional rotate mode. Runs either one operation per `en` pulse or as a counted burst of N shifts under a start/busy/done handshake. Used wherever the design needs serialise/deserialise or bit-rotate operations wider than a fixed 4-bit serial shifter.

## Interface
- `WIDTH`, 8: register width; legal range is 2 or more.
- `CNT_W`, $clog2(WIDTH)+1: width of the burst count.
- `clk`  in  1: clock; all state changes on its rising edge.
- `rst`  in  1: reset; one clock, synchronous, active-high.
- `en`  in  1: perform one `mode` operation this edge (IDLE only).
- `mode`  in  2: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- `rotate`  in  1: 1 = the bit shifted out is fed back in instead of the serial input.
- `s_in_r`  in  1: serial input entering the MSB on a right shift.
- `s_in_l`  in  1: serial input entering the LSB on a left shift.
- `p_in`  in  WIDTH: parallel load data.
- `start`  in  1: request a burst operation (IDLE only).
- `count`  in  CNT_W: number of shifts in the burst.
- `q`  out  WIDTH: register contents.
- `s_out`  out  1: registered copy of the bit that left the register on the most recent shift.
- `busy`  out  1: burst in progress.
- `done`  out  1: one-cycle pulse marking burst completion.

## Operation
- **Reset** (rst=1 at an edge): q=0, s_out=0, state=IDLE, busy=0, done=0.
  - Reset overrides everything, including a burst in progress; that burst is abandoned with no done pulse.
- **Right shift**: q <= {rotate ? q[0] : s_in_r, q[WIDTH-1:1]}; s_out <= q[0].
- **Left shift**: q <= {q[WIDTH-2:0], rotate ? q[WIDTH-1] : s_in_l}; s_out <= q[WIDTH-1].
- **Load**: q <= p_in; s_out unchanged.
- **Hold**: q and s_out unchanged.
- **IDLE state**:
  - `start` has priority over `en`.
  - With `start`=0 and `en`=1, execute `mode` once.
  - With neither asserted, hold.
- **start accepted in IDLE**:
  - mode 01/10 with count>0: latch mode, rotate and count; go to SHIFT. No shift occurs on the accepting edge.
  - count=0 with a shift mode: go to DONE with no change to q.
  - mode 11: load on the accepting edge, then go to DONE.
  - mode 00: go to DONE with no change to q.
- **SHIFT state**:
  - Perform one shift per edge using the latched mode and rotate. Serial inputs are sampled live each edge, not latched.
  - Decrement the remaining count; after the shift that takes remaining from 1 to 0, go to DONE.
  - `start`, `en`, `mode`, `rotate`, `count` and `p_in` are ignored.
- **DONE state**: lasts one cycle, then goes to IDLE. `en` and `start` are ignored in DONE.
- **Counts above WIDTH** are legal.
  - Rotate bursts wrap (rotate by count mod WIDTH).
  - Non-rotate bursts fill the register entirely from the serial input.

## Timing
- Single-step latency: q and s_out update on the edge where `en` is sampled high.
- Burst accepted at edge k with count N>0:
  - Shifts occur at edges k+1 … k+N.
  - busy=1 during the N cycles following edge k.
  - done=1 for exactly the cycle after edge k+N; busy=0 in that cycle.
  - A new `start` is accepted no earlier than edge k+N+2.
- Burst accepted at edge k with count=0, or with mode 00/11: done=1 in the cycle after edge k; busy never asserts.
- busy and done are decoded directly from the state register (glitch-free, no combinational input paths).
- busy and done are never high simultaneously.

## Structure
- Package `univ_shift_pkg` holds:
  - the mode encodings MODE_HOLD, MODE_SHR, MODE_SHL and MODE_LOAD;
  - the state type with values IDLE, SHIFT and DONE.
- One combinational sub-module, `usr_step`, computes next-q and shifted-out bit from (q, mode, rotate, s_in_r, s_in_l, p_in). It is shared by the single-step and burst paths.
- The top level holds the state register, the latched mode/rotate, the down-counter, q and s_out.

## Test plan
All scenarios use WIDTH=8.
1. Load then step:
   - p_in=A5, mode=11, en=1 → q=A5.
   - Then mode=01, s_in_r=1, en=1 → q=D2, s_out=1.
2. Left step: q=A5, mode=10, s_in_l=0, en=1 → q=4A, s_out=1. With rotate=1 instead → q=4B.
3. Rotate burst: q=A5, start, mode=01, rotate=1, count=3 → busy 3 cycles, then done 1 cycle; q=B4, s_out=1. Toggling en/mode/start during busy has no effect.
4. Fill burst: q=00, start, mode=10, rotate=0, s_in_l=1, count=8 → after 8 shifts q=FF, s_out=0; done exactly one cycle after the 8th shift.
5. Degenerate starts:
   - count=0 with mode 01 → done next cycle, busy stays 0, q unchanged.
   - start with mode=11, p_in=3C → q=3C and done next cycle.
6. Reset mid-burst: rst=1 during the 2nd shift of a count=5 burst → next edge q=00, s_out=0, busy=0, no done pulse. After release, a new start is accepted immediately.
